codec_init_seq: RTL and testbench
=================================

CODEC_INIT_SEQ -- requirements
Module: codec_init_seq

Interface
REQ-001 Parameter SLAVE_ADDR, default 8'h35, is the codec I2C slave address driven on slave_addr.
REQ-002 Parameter GAP_CYCLES, default 16'd1000, is the idle sys_clk cycles inserted between consecutive writes.
REQ-003 Parameter TIMEOUT_CYCLES, default 24'd1_000_000, is the watchdog limit per write (used only under the Configuration macro).
REQ-004 Port sys_clk, input, 1: sole clock; all logic on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port start, input, 1: begins the init sequence when sampled high in IDLE.
REQ-007 Port i2c_free, input, 1: I2C command engine free flag; high means idle.
REQ-008 Port i2c_enable, output, 1: single-cycle command strobe to the I2C engine.
REQ-009 Port slave_addr, output, 8: constant SLAVE_ADDR.
REQ-010 Port i2c_reg, output, 8: register address of the current entry.
REQ-011 Port i2c_data, output, 8: data byte of the current entry.
REQ-012 Port busy, output, 1: high from the cycle after start is accepted until DONE or ERROR.
REQ-013 Port done, output, 1: sticky; high once all 8 entries have been written.
REQ-014 Port error, output, 1: sticky; high on watchdog expiry (forced 0 when the macro is absent).

Function
REQ-015 Internal ROM holds 8 entries {reg,data}, indices 0-7: {0F,00},{07,0A},{08,00},{05,00},{02,79},{03,79},{22,50},{25,C0}.
REQ-016 States: IDLE, ISSUE, WAIT_ACCEPT, WAIT_DONE, GAP, DONE, ERROR.
REQ-017 IDLE: if start=1 and i2c_free=1, idx<=0 and go to ISSUE; if start=1 and i2c_free=0, stay in IDLE and re-sample start next cycle.
REQ-018 i2c_reg/i2c_data are registered from ROM[idx] and stable from entry into ISSUE until exit from WAIT_DONE.
REQ-019 ISSUE: i2c_enable=1 for exactly one cycle; next state is WAIT_ACCEPT.
REQ-020 WAIT_ACCEPT: go to WAIT_DONE on i2c_free=0; stay otherwise.
REQ-021 WAIT_DONE: on i2c_free=1, load the gap counter with GAP_CYCLES and go to GAP.
REQ-022 GAP: decrement the counter; at 0, if idx=7 go to DONE, else idx<=idx+1 and go to ISSUE; GAP_CYCLES=0 gives a one-cycle GAP.
REQ-023 DONE: done=1, busy=0; start is ignored; exit only by reset.
REQ-024 i2c_enable is never asserted outside ISSUE; at most one outstanding command at any time.
REQ-025 idx is 3 bits and never wraps; the transition from idx=7 goes only to DONE.
REQ-026 start held high throughout the sequence has no effect after acceptance.

Reset
REQ-027 reset=1 asynchronously forces state=IDLE, idx=0, counters=0, i2c_enable=0, busy=0, done=0, error=0, i2c_reg=0, i2c_data=0.
REQ-028 Reset mid-write drops i2c_enable within the same cycle; no resume; a new start restarts from idx 0.
REQ-029 The first start is accepted on the first rising edge after reset deasserts.

Configuration
REQ-030 With macro CODEC_INIT_TIMEOUT_EN defined, a 24-bit watchdog clears on entry to WAIT_ACCEPT, counts in WAIT_ACCEPT and WAIT_DONE, and on reaching TIMEOUT_CYCLES moves to ERROR (busy=0, error=1, exit only by reset).
REQ-031 Without CODEC_INIT_TIMEOUT_EN, no watchdog logic exists, error is tied 0, and WAIT states wait indefinitely.

Verification
REQ-032 Normal run: model I2C engine (free low 2 cycles after enable, for 50 cycles), GAP_CYCLES=4, start pulse -> 8 enable pulses with {reg,data} matching REQ-015 in order, then done=1, busy=0.
REQ-033 Handshake: hold i2c_free=1 after enable -> FSM stays in WAIT_ACCEPT, no second enable pulse.
REQ-034 Busy bus at start: i2c_free=0, start=1 for 10 cycles, then i2c_free=1 -> first enable pulse 2 cycles after i2c_free rises.
REQ-035 Reset during entry 3 in WAIT_DONE -> outputs zero immediately; subsequent start -> first write is {0F,00}.
REQ-036 With CODEC_INIT_TIMEOUT_EN and TIMEOUT_CYCLES=100, i2c_free stuck low after entry 0 -> error=1 at cycle 100, busy=0, no further enable pulses.
REQ-037 After done=1, another start pulse -> no enable pulse, done remains 1.

Source files
------------

// File: rtl/codec_init_seq.sv
// Codec register init sequencer: walks an 8-entry {reg,data} ROM and issues one I2C write per entry.
// Optional per-write watchdog is compiled in with `define CODEC_INIT_TIMEOUT_EN.
module codec_init_seq #(
  parameter logic [7:0]  SLAVE_ADDR     = 8'h35,
  parameter logic [15:0] GAP_CYCLES     = 16'd1000,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       start,
  input  logic       i2c_free,
  output logic       i2c_enable,
  output logic [7:0] slave_addr,
  output logic [7:0] i2c_reg,
  output logic [7:0] i2c_data,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_ACCEPT, WAIT_DONE, GAP, DONE, ERROR
  } state_t;

  state_t      state, next_state;
  logic [2:0]  idx;
  logic [15:0] gap_cnt;

  function automatic logic [15:0] rom_entry(input logic [2:0] i);
    case (i)
      3'd0:    rom_entry = 16'h0F00;
      3'd1:    rom_entry = 16'h070A;
      3'd2:    rom_entry = 16'h0800;
      3'd3:    rom_entry = 16'h0500;
      3'd4:    rom_entry = 16'h0279;
      3'd5:    rom_entry = 16'h0379;
      3'd6:    rom_entry = 16'h2250;
      default: rom_entry = 16'h25C0;
    endcase
  endfunction

`ifdef CODEC_INIT_TIMEOUT_EN
  logic [23:0] wd_cnt;
  logic        wd_expired;
  assign wd_expired = ((state == WAIT_ACCEPT) || (state == WAIT_DONE)) &&
                      (wd_cnt == TIMEOUT_CYCLES - 24'd1);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    next_state = state;
    case (state)
      IDLE:        if (start && i2c_free) next_state = ISSUE;
      ISSUE:       next_state = WAIT_ACCEPT;
      WAIT_ACCEPT: if (!i2c_free) next_state = WAIT_DONE;
      WAIT_DONE:   if (i2c_free) next_state = GAP;
      GAP:         if (gap_cnt == 16'd0) next_state = (idx == 3'd7) ? DONE : ISSUE;
      DONE:        next_state = DONE;
      ERROR:       next_state = ERROR;
      default:     next_state = IDLE;
    endcase
`ifdef CODEC_INIT_TIMEOUT_EN
    // The watchdog wins over a same-cycle handshake edge.
    if (wd_expired) next_state = ERROR;
`endif
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Entry registers load only on the way into ISSUE, so they hold through the whole write.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      idx      <= 3'd0;
      gap_cnt  <= 16'd0;
      i2c_reg  <= 8'd0;
      i2c_data <= 8'd0;
    end else begin
      if (state == IDLE && next_state == ISSUE) begin
        idx                 <= 3'd0;
        {i2c_reg, i2c_data} <= rom_entry(3'd0);
      end else if (state == GAP && next_state == ISSUE) begin
        idx                 <= idx + 3'd1;
        {i2c_reg, i2c_data} <= rom_entry(idx + 3'd1);
      end
      if (state == WAIT_DONE && next_state == GAP) gap_cnt <= GAP_CYCLES;
      else if (state == GAP && gap_cnt != 16'd0)   gap_cnt <= gap_cnt - 16'd1;
    end
  end

`ifdef CODEC_INIT_TIMEOUT_EN
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset)                                              wd_cnt <= 24'd0;
    else if (state == ISSUE)                                wd_cnt <= 24'd0;
    else if (state == WAIT_ACCEPT || state == WAIT_DONE)    wd_cnt <= wd_cnt + 24'd1;
  end
  assign error = (state == ERROR);
`else
  assign error = 1'b0;
`endif

  assign i2c_enable = (state == ISSUE);
  assign slave_addr = SLAVE_ADDR;
  assign busy       = (state == ISSUE) || (state == WAIT_ACCEPT) ||
                      (state == WAIT_DONE) || (state == GAP);
  assign done       = (state == DONE);

endmodule

// File: tb/tb_codec_init_seq.sv
// Directed bench for codec_init_seq: reset, full sequence, handshake, busy bus, mid-write reset, post-done start.
// The watchdog step is compiled only with CODEC_INIT_TIMEOUT_EN defined.
module tb_codec_init_seq;

  logic       sys_clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       i2c_free;
  logic       i2c_enable;
  logic [7:0] slave_addr, i2c_reg, i2c_data;
  logic       busy, done, error;

  logic       eng_on = 1'b0;
  logic       free_eng = 1'b1;
  logic       free_manual = 1'b1;
  int         eng_cnt = 0;
  int         en_cycles = 0;
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  assign i2c_free = eng_on ? free_eng : free_manual;

  codec_init_seq #(
    .SLAVE_ADDR(8'h35), .GAP_CYCLES(16'd4), .TIMEOUT_CYCLES(24'd100)
  ) dut (
    .sys_clk(sys_clk), .reset(reset), .start(start), .i2c_free(i2c_free),
    .i2c_enable(i2c_enable), .slave_addr(slave_addr), .i2c_reg(i2c_reg),
    .i2c_data(i2c_data), .busy(busy), .done(done), .error(error)
  );

  // I2C engine model: bus goes busy 2 cycles after the strobe, stays busy 50 cycles.
  always @(negedge sys_clk) begin
    if (reset) begin
      eng_cnt  = 0;
      free_eng = 1'b1;
    end else begin
      if (i2c_enable) begin
        en_cycles++;
        got_q.push_back({i2c_reg, i2c_data});
      end
      if (eng_cnt == 0) begin
        if (i2c_enable && eng_on) eng_cnt = 1;
      end else begin
        eng_cnt++;
        if (eng_cnt == 3) free_eng = 1'b0;
        if (eng_cnt == 53) begin
          free_eng = 1'b1;
          eng_cnt  = 0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    reset = 1'b1;
    repeat (2) @(negedge sys_clk);
    reset = 1'b0;
  endtask

  initial begin
    int base, base_en, k, lat;
    bit hit;
    exp_q = '{16'h0F00, 16'h070A, 16'h0800, 16'h0500,
              16'h0279, 16'h0379, 16'h2250, 16'h25C0};

    // Reset state
    repeat (2) @(negedge sys_clk);
    chk("rst_enable", i2c_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_reg", i2c_reg, 0);
    chk("rst_data", i2c_data, 0);
    chk("slave_addr", slave_addr, 8'h35);

    // Full sequence; start held high the whole time, accepted on first edge after reset
    eng_on = 1'b1;
    start  = 1'b1;
    base    = got_q.size();
    base_en = en_cycles;
    reset   = 1'b0;
    @(negedge sys_clk);
    chk("first_start_busy", busy, 1);
    chk("first_entry_reg", i2c_reg, 8'h0F);
    hit = 0;
    for (int i = 0; i < 3000; i++) begin
      if (done) begin hit = 1; break; end
      @(negedge sys_clk);
    end
    chk("done_reached", hit, 1);
    chk("write_count", got_q.size() - base, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("entry_%0d", i), got_q[base + i], exp_q[i]);
    chk("enable_cycles", en_cycles - base_en, 8);
    chk("done_busy", busy, 0);
    chk("done_error", error, 0);
    start = 1'b0;

    // Start after done is ignored
    @(negedge sys_clk);
    base_en = en_cycles;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    repeat (10) @(negedge sys_clk);
    chk("post_done_enables", en_cycles - base_en, 0);
    chk("post_done_done", done, 1);
    chk("post_done_busy", busy, 0);

    // Handshake: bus never goes busy -> single strobe, stays busy waiting
    eng_on = 1'b0;
    free_manual = 1'b1;
    do_reset();
    base_en = en_cycles;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    repeat (20) @(negedge sys_clk);
    chk("hs_enable_cycles", en_cycles - base_en, 1);
    chk("hs_busy", busy, 1);
    chk("hs_enable_now", i2c_enable, 0);
    chk("hs_reg_data", {i2c_reg, i2c_data}, 16'h0F00);

    // Busy bus at start
    free_manual = 1'b0;
    do_reset();
    base_en = en_cycles;
    start = 1'b1;
    repeat (10) @(negedge sys_clk);
    chk("bb_busy_held", busy, 0);
    chk("bb_no_enable", en_cycles - base_en, 0);
    free_manual = 1'b1;
    lat = 0;
    for (k = 1; k <= 4; k++) begin
      @(negedge sys_clk);
      if (i2c_enable) begin lat = k; break; end
    end
    chk("bb_latency_ok", (lat >= 1 && lat <= 2), 1);
    start = 1'b0;

    // Reset in WAIT_DONE of entry 3, then restart from entry 0
    free_manual = 1'b1;
    eng_on = 1'b1;
    do_reset();
    base = got_q.size();
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    hit = 0;
    for (int i = 0; i < 2000; i++) begin
      if (got_q.size() - base >= 4 && !i2c_free) begin hit = 1; break; end
      @(negedge sys_clk);
    end
    @(negedge sys_clk);
    chk("mid_reached", hit, 1);
    chk("mid_entry3", got_q[base + 3], 16'h0500);
    chk("mid_busy_before", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_enable", i2c_enable, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_reg", i2c_reg, 0);
    chk("mid_rst_data", i2c_data, 0);
    chk("mid_rst_done", done, 0);
    repeat (2) @(negedge sys_clk);
    base = got_q.size();
    start = 1'b1;
    reset = 1'b0;
    @(negedge sys_clk);
    start = 1'b0;
    hit = 0;
    for (int i = 0; i < 20; i++) begin
      if (got_q.size() > base) begin hit = 1; break; end
      @(negedge sys_clk);
    end
    chk("restart_seen", hit, 1);
    chk("restart_first", got_q[base], 16'h0F00);

`ifdef CODEC_INIT_TIMEOUT_EN
    // Watchdog: bus stuck busy after entry 0
    eng_on = 1'b0;
    free_manual = 1'b1;
    do_reset();
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    chk("wd_issue", i2c_enable, 1);
    free_manual = 1'b0;
    base_en = en_cycles;
    repeat (100) @(negedge sys_clk);
    chk("wd_error_before", error, 0);
    @(negedge sys_clk);
    chk("wd_error_at", error, 1);
    chk("wd_busy", busy, 0);
    repeat (10) @(negedge sys_clk);
    chk("wd_no_enable", en_cycles - base_en, 0);
    chk("wd_error_sticky", error, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
